// File: rtl/cga_pkg.sv
// rtl/cga_pkg.sv - shared sub-phase offset constants and ISA arbiter state type
package cga_pkg;
    localparam int OFF_CRTC     = 0;
    localparam int OFF_RD_FIRST = 1;
    localparam int OFF_CHAR     = 2;
    localparam int OFF_ATT      = 3;
    localparam int OFF_PIPE     = 4;
    localparam int OFF_ISA_MIN  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } isa_state_t;
endpackage

// File: rtl/cga_isa_arbiter.sv
// rtl/cga_isa_arbiter.sv - ISA request/grant FSM keeping a guard gap ahead of each VRAM read
module cga_isa_arbiter import cga_pkg::*; #(
    parameter int SUB        = 16,
    parameter int ISA_OP_LEN = 3,
    parameter int ISA_GUARD  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic                   resync,
    input  logic                   isa_req,
    input  logic [$clog2(SUB)-1:0] offset,
    output logic                   isa_grant,
    output logic                   isa_busy
);
    localparam int OW = $clog2(SUB);
    localparam int LW = (ISA_OP_LEN > 1) ? $clog2(ISA_OP_LEN) : 1;
    // Last start offset whose op still ends ISA_GUARD idle cycles before the next sub-phase's read at offset 1.
    localparam logic [OW-1:0] WIN_LO = OW'(OFF_ISA_MIN);
    localparam logic [OW-1:0] WIN_HI = OW'(SUB - ISA_GUARD - ISA_OP_LEN);

    isa_state_t    state_q, state_d;
    logic [LW-1:0] left_q, left_d;
    logic          grant_q, grant_d;
    logic          in_window;

    assign in_window = (offset >= WIN_LO) && (offset <= WIN_HI);

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        grant_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (run && !resync && isa_req && in_window) begin
                    state_d = BUSY;
                    left_d  = LW'(ISA_OP_LEN - 1);
                    grant_d = 1'b1;
                end
            end
            BUSY: begin
                if (left_q == '0) begin
                    state_d = IDLE;
                end else begin
                    left_d = left_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            left_q  <= '0;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            grant_q <= grant_d;
        end
    end

    assign isa_grant = grant_q;
    assign isa_busy  = (state_q == BUSY);
endmodule

// File: rtl/cga_slot_sequencer.sv
// rtl/cga_slot_sequencer.sv - parametrised CGA character-period sequencer with mode switch, resync and ISA arbiter
module cga_slot_sequencer import cga_pkg::*; #(
    parameter int PERIOD     = 32,
    parameter int SUBPHASES  = 2,
    parameter int ISA_OP_LEN = 3,
    parameter int ISA_GUARD  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      hres_mode,
    input  logic                      resync,
    input  logic                      isa_req,
    output logic [$clog2(PERIOD)-1:0] clk_seq,
    output logic                      lclk,
    output logic                      hclk,
    output logic                      crtc_clk,
    output logic                      vram_read,
    output logic                      vram_read_a0,
    output logic                      vram_read_char,
    output logic                      vram_read_att,
    output logic                      charrom_read,
    output logic                      disp_pipeline,
    output logic                      isa_grant,
    output logic                      isa_busy,
    output logic                      mode_active
);
    localparam int CW  = $clog2(PERIOD);
    localparam int SUB = PERIOD / SUBPHASES;
    localparam int OW  = $clog2(SUB);

    if (SUB < 5 + ISA_OP_LEN + ISA_GUARD) begin : g_bad_sub
        $error("cga_slot_sequencer: sub-phase of %0d steps too short for ISA op plus guard", SUB);
    end
    if ((PERIOD & (PERIOD - 1)) != 0 || (SUBPHASES & (SUBPHASES - 1)) != 0) begin : g_bad_pow2
        $error("cga_slot_sequencer: PERIOD and SUBPHASES must be powers of 2");
    end

    localparam logic [OW-1:0] O_CRTC  = OW'(OFF_CRTC);
    localparam logic [OW-1:0] O_RD_LO = OW'(OFF_RD_FIRST);
    localparam logic [OW-1:0] O_CHAR  = OW'(OFF_CHAR);
    localparam logic [OW-1:0] O_ATT   = OW'(OFF_ATT);
    localparam logic [OW-1:0] O_PIPE  = OW'(OFF_PIPE);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic          run_q, run_d;
    logic [OW-1:0] offset;
    logic          active;

    always_comb begin
        run_d  = 1'b1;
        cnt_d  = (!run_q || resync) ? '0 : cnt_q + CW'(1);
        // Mode only changes on the step that precedes step 0, so a period is never split between modes.
        mode_d = (cnt_q == CW'(PERIOD - 1) || resync) ? hres_mode : mode_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            mode_q <= 1'b0;
            run_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            run_q  <= run_d;
        end
    end

    assign offset = cnt_q[OW-1:0];
    assign active = mode_q || ({1'b0, cnt_q} < (CW + 1)'(SUB));

    assign clk_seq        = cnt_q;
    assign mode_active    = mode_q;
    assign lclk           = run_q && (cnt_q == '0);
    assign hclk           = run_q && (offset == O_CRTC);
    assign crtc_clk       = run_q && active && (offset == O_CRTC);
    assign vram_read      = run_q && (offset >= O_RD_LO) && (offset <= O_ATT);
    assign vram_read_a0   = run_q && (offset == O_ATT);
    assign vram_read_char = run_q && active && (offset == O_CHAR);
    assign vram_read_att  = run_q && active && (offset == O_ATT);
    assign charrom_read   = run_q && active && (offset == O_ATT);
    assign disp_pipeline  = run_q && active && (offset == O_PIPE);

    cga_isa_arbiter #(
        .SUB        (SUB),
        .ISA_OP_LEN (ISA_OP_LEN),
        .ISA_GUARD  (ISA_GUARD)
    ) u_isa_arbiter (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run_q),
        .resync    (resync),
        .isa_req   (isa_req),
        .offset    (offset),
        .isa_grant (isa_grant),
        .isa_busy  (isa_busy)
    );
endmodule

// File: tb/tb_cga_slot_sequencer.sv
// tb/tb_cga_slot_sequencer.sv - randomized model-checked bench for cga_slot_sequencer (32/2 and 64/4)
module tb_cga_slot_sequencer;
    localparam int SUB = 16;
    localparam int OPL = 3;
    localparam int GRD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, hres_mode, resync, isa_req;
    logic [4:0] seq0;
    logic [5:0] seq1;
    wire  [11:0] o0, o1;

    cga_slot_sequencer #(.PERIOD(32), .SUBPHASES(2)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .hres_mode(hres_mode), .resync(resync), .isa_req(isa_req),
        .clk_seq(seq0), .lclk(o0[11]), .hclk(o0[10]), .crtc_clk(o0[9]), .vram_read(o0[8]),
        .vram_read_a0(o0[7]), .vram_read_char(o0[6]), .vram_read_att(o0[5]), .charrom_read(o0[4]),
        .disp_pipeline(o0[3]), .isa_grant(o0[2]), .isa_busy(o0[1]), .mode_active(o0[0])
    );

    cga_slot_sequencer #(.PERIOD(64), .SUBPHASES(4)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .hres_mode(hres_mode), .resync(resync), .isa_req(isa_req),
        .clk_seq(seq1), .lclk(o1[11]), .hclk(o1[10]), .crtc_clk(o1[9]), .vram_read(o1[8]),
        .vram_read_a0(o1[7]), .vram_read_char(o1[6]), .vram_read_att(o1[5]), .charrom_read(o1[4]),
        .disp_pipeline(o1[3]), .isa_grant(o1[2]), .isa_busy(o1[1]), .mode_active(o1[0])
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: period position, mode in effect and remaining busy cycles per instance.
    int m_per[2] = '{32, 64};
    int m_step[2], m_mode[2], m_run[2], m_busy[2], m_grant[2];

    function automatic logic [11:0] exp_out(input int d);
        int off;
        bit act, r;
        off = m_step[d] % SUB;
        act = (m_mode[d] != 0) || (m_step[d] < SUB);
        r   = (m_run[d] != 0);
        return {r && m_step[d] == 0, r && off == 0, r && act && off == 0, r && off >= 1 && off <= 3,
                r && off == 3, r && act && off == 2, r && act && off == 3, r && act && off == 3,
                r && act && off == 4, m_grant[d] != 0, m_busy[d] > 0, m_mode[d] != 0};
    endfunction

    task automatic advance(input logic rn, input logic h, input logic r, input logic q);
        for (int d = 0; d < 2; d++) begin
            if (!rn) begin
                m_step[d] = 0; m_mode[d] = 0; m_run[d] = 0; m_busy[d] = 0; m_grant[d] = 0;
            end else begin
                int off;
                off = m_step[d] % SUB;
                if (m_busy[d] > 0) begin
                    m_busy[d]--;
                    m_grant[d] = 0;
                end else if (m_run[d] != 0 && !r && q && off >= 4 && off <= SUB - GRD - OPL) begin
                    m_busy[d]  = OPL;
                    m_grant[d] = 1;
                end else begin
                    m_grant[d] = 0;
                end
                if (m_step[d] == m_per[d] - 1 || r) m_mode[d] = h;
                m_step[d] = (m_run[d] == 0 || r) ? 0 : (m_step[d] + 1) % m_per[d];
                m_run[d]  = 1;
            end
        end
    endtask

    int ncyc = 0;
    int last_busy[2] = '{-100, -100};
    int last_rsy = -100;
    logic [31:0] char0, vr0, busy0;
    logic [63:0] char1;
    int g_step, busy_cnt;
    bit g_seen;

    task automatic cyc(input logic rn, input logic h, input logic r, input logic q);
        @(negedge clk);
        ncyc++;
        chk("out32", 32'(o0), 32'(exp_out(0)));
        chk("out64", 32'(o1), 32'(exp_out(1)));
        chk("seq32", 32'(seq0), m_step[0]);
        chk("seq64", 32'(seq1), m_step[1]);
        if (o0[1]) last_busy[0] = ncyc;
        if (o1[1]) last_busy[1] = ncyc;
        if (ncyc - last_rsy > 40) begin
            if (o0[8]) chk("guard32", 32'(ncyc - last_busy[0] > GRD), 1);
            if (o1[8]) chk("guard64", 32'(ncyc - last_busy[1] > GRD), 1);
        end
        if (o0[6]) char0 |= 32'(1) << seq0;
        if (o0[8]) vr0   |= 32'(1) << seq0;
        if (o0[1]) begin busy0 |= 32'(1) << seq0; busy_cnt++; end
        if (o1[6]) char1 |= 64'(1) << seq1;
        if (o0[2] && !g_seen) begin g_seen = 1; g_step = int'(seq0); end
        reset_n = rn; hres_mode = h; resync = r; isa_req = q;
        if (r) last_rsy = ncyc;
        advance(rn, h, r, q);
    endtask

    task automatic clear_obs();
        char0 = '0; vr0 = '0; busy0 = '0; char1 = '0; g_seen = 0; g_step = -1; busy_cnt = 0;
    endtask

    task automatic run_to(input int s, input logic h);
        int n;
        n = 0;
        while (m_step[0] != s && n < 80) begin
            cyc(1, h, 0, 0);
            n++;
        end
        if (n >= 80) chk("run_to_timeout", 32'(n), 0);
    endtask

    task automatic req_until_grant(input logic h);
        int n;
        n = 0;
        while (!g_seen && n < 80) begin
            cyc(1, h, 0, 1);
            n++;
        end
        if (!g_seen) chk("grant_timeout", 32'(n), 0);
    endtask

    initial begin
        bit hold;
        logic h, r, q, rn;
        reset_n = 1'b0; hres_mode = 1'b0; resync = 1'b0; isa_req = 1'b0;
        advance(0, 0, 0, 0);
        clear_obs();

        repeat (10) cyc(0, 0, 0, 0);
        chk("reset_outputs", 32'(o0) | 32'(o1) | 32'(seq0) | 32'(seq1), 0);

        repeat (70) cyc(1, 1, 0, 0);
        clear_obs();
        repeat (64) cyc(1, 1, 0, 0);
        chk("char_hres1", char0, 32'h0004_0004);
        chk("char64_lo", char1[31:0], 32'h0004_0004);
        chk("char64_hi", char1[63:32], 32'h0004_0004);

        repeat (70) cyc(1, 0, 0, 0);
        clear_obs();
        repeat (64) cyc(1, 0, 0, 0);
        chk("char_hres0", char0, 32'h0000_0004);
        chk("vram_read_hres0", vr0, 32'h000E_000E);
        chk("char64_hres0", char1[31:0] | char1[63:32], 32'h0000_0004);

        run_to(7, 0);
        cyc(1, 1, 0, 0);
        clear_obs();
        repeat (24) cyc(1, 1, 0, 0);
        chk("no_char18", char0, 0);
        cyc(1, 1, 0, 0);
        chk("mode_at_step0", 32'(o0[0]), 1);

        run_to(0, 1);
        clear_obs();
        req_until_grant(1);
        repeat (8) cyc(1, 1, 0, 0);
        chk("grant_from_0", 32'(g_step), 5);
        chk("busy_5_to_7", busy0, 32'h0000_00E0);

        run_to(12, 1);
        clear_obs();
        req_until_grant(1);
        chk("grant_from_12", 32'(g_step), 21);

        run_to(7, 1);
        clear_obs();
        cyc(1, 1, 0, 1);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 1, 0, 0);
        chk("resync_seq0", 32'(seq0), 0);
        repeat (6) cyc(1, 1, 0, 0);
        chk("grant_at_8", 32'(g_step), 8);
        chk("busy_len_resync", 32'(busy_cnt), OPL);

        run_to(4, 1);
        cyc(1, 1, 0, 1);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("reset_mid_op", 32'(o0[1]) | 32'(o0[2]), 0);
        cyc(1, 1, 0, 0);

        hold = 0;
        h = 1'b1;
        repeat (3000) begin
            if ($urandom_range(0, 99) == 0) h = ~h;
            r  = ($urandom_range(0, 59) == 0);
            rn = ($urandom_range(0, 799) != 0);
            if (m_grant[0] != 0 || !rn) hold = 0;
            q = hold || ($urandom_range(0, 7) == 0);
            if (q) hold = 1;
            cyc(rn, h, r, q);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
